seven_sd_capture: RTL and testbench

//  Receive side of the multiplexed seven-segment bus driven by SevenSdSignalGen.

---
 rtl/seven_sd_pkg.sv | 22 ++
 rtl/seven_sd_digit_qualifier.sv | 55 +++++
 rtl/seven_sd_capture.sv | 75 +++++++
 tb/tb_seven_sd_capture.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/seven_sd_pkg.sv
// seven_sd_pkg: shared constants, FSM states and anode decode helpers for the seven-segment capture path
package seven_sd_pkg;
    localparam int DIGITS = 4;
    localparam int SEG_W = 8;
    localparam int VALUE_W = 32;
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HELD} state_e;
    function automatic logic onehot_low(input logic [DIGITS-1:0] a);
        return $onehot(~a);
    endfunction
    function automatic logic multi_low(input logic [DIGITS-1:0] a);
        return $countones(~a) > 1;
    endfunction
    function automatic logic [IDX_W-1:0] digit_idx(input logic [DIGITS-1:0] a);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < DIGITS; i++)
            if (!a[i]) idx = IDX_W'(i);
        return idx;
    endfunction
endpackage

// File: rtl/seven_sd_digit_qualifier.sv
// seven_sd_digit_qualifier: synchronises the bus and strobes a capture once a one-hot digit sample has been stable long enough
module seven_sd_digit_qualifier
    import seven_sd_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SEG_W-1:0]  seg_in,
    input  logic [DIGITS-1:0] anode_in,
    output logic              capture,
    output logic [IDX_W-1:0]  digit,
    output logic [SEG_W-1:0]  seg,
    output logic              multi
);
    localparam int SMP_W = DIGITS + SEG_W;
    localparam logic [CNT_W-1:0] CAP_CNT = CNT_W'(SETTLE_CYCLES - 2);
    localparam logic [CNT_W-1:0] SAT_CNT = CNT_W'(SETTLE_CYCLES);
    logic [SYNC_STAGES-1:0][SMP_W-1:0] sync_q, sync_d;
    logic [SMP_W-1:0] prev_q, prev_d, sample;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_e state_q, state_d;
    logic hot, same;
    always_comb begin
        sync_d[0] = {anode_in, seg_in};
        for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
        sample = sync_q[SYNC_STAGES-1];
        prev_d = sample;
        hot = onehot_low(sample[SMP_W-1:SEG_W]);
        same = sample == prev_q;
        // cnt_q counts matching cycles after the first, so capture lands on the SETTLE_CYCLES-th cycle of a sample
        capture = hot && same && state_q == ST_SETTLE && cnt_q == CAP_CNT;
        cnt_d = (!hot || !same) ? '0 : (cnt_q == SAT_CNT ? cnt_q : cnt_q + 1'b1);
        state_d = !hot ? ST_IDLE : !same ? ST_SETTLE : capture ? ST_HELD :
                  state_q == ST_IDLE ? ST_SETTLE : state_q;
        digit = digit_idx(sample[SMP_W-1:SEG_W]);
        seg = sample[SEG_W-1:0];
        multi = multi_low(sample[SMP_W-1:SEG_W]);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= '1;
            cnt_q <= '0;
            state_q <= ST_IDLE;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            cnt_q <= cnt_d;
            state_q <= state_d;
        end
    end
endmodule

// File: rtl/seven_sd_capture.sv
// seven_sd_capture: rebuilds the 32-bit segment word shown on a multiplexed active-low seven-segment bus
module seven_sd_capture
    import seven_sd_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SEG_W-1:0]   segIn,
    input  logic [DIGITS-1:0]  anodeIn,
    output logic [VALUE_W-1:0] value,
    output logic               frameValid,
    output logic               valueChanged,
    output logic [DIGITS-1:0]  digitSeen,
    output logic               anodeError
);
    logic capture, multi, full;
    logic [IDX_W-1:0] digit;
    logic [SEG_W-1:0] seg;
    logic [DIGITS-1:0][SEG_W-1:0] shadow_q, shadow_d;
    logic [DIGITS-1:0] seen_q, seen_d;
    logic [VALUE_W-1:0] value_q, value_d;
    logic fv_q, fv_d, vc_q, vc_d, err_q, err_d, first_q, first_d;
    seven_sd_digit_qualifier #(
        .SYNC_STAGES(SYNC_STAGES),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .CNT_W(CNT_W)
    ) u_qual (
        .clk(clk),
        .rst(rst),
        .seg_in(segIn),
        .anode_in(anodeIn),
        .capture(capture),
        .digit(digit),
        .seg(seg),
        .multi(multi)
    );
    always_comb begin
        full = seen_q == '1;
        shadow_d = shadow_q;
        if (capture) shadow_d[digit] = seg;
        seen_d = (full ? '0 : seen_q) | (capture ? DIGITS'(1) << digit : '0);
        value_d = full ? shadow_q : value_q;
        fv_d = full;
        vc_d = full && (shadow_q != value_q || first_q);
        first_d = first_q && !full;
        err_d = err_q | multi;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= {DIGITS{SEG_BLANK}};
            seen_q <= '0;
            value_q <= '1;
            fv_q <= 1'b0;
            vc_q <= 1'b0;
            err_q <= 1'b0;
            first_q <= 1'b1;
        end else begin
            shadow_q <= shadow_d;
            seen_q <= seen_d;
            value_q <= value_d;
            fv_q <= fv_d;
            vc_q <= vc_d;
            err_q <= err_d;
            first_q <= first_d;
        end
    end
    assign value = value_q;
    assign frameValid = fv_q;
    assign valueChanged = vc_q;
    assign digitSeen = seen_q;
    assign anodeError = err_q;
endmodule

// File: tb/tb_seven_sd_capture.sv
// tb_seven_sd_capture: drives a multiplexed display model into the capture block and scores published frames
module tb_seven_sd_capture;
    logic clk = 1'b0, rst = 1'b1;
    logic [7:0] segIn = 8'hFF;
    logic [3:0] anodeIn = 4'hF;
    logic [31:0] value;
    logic frameValid, valueChanged, anodeError;
    logic [3:0] digitSeen;
    int n_checks = 0, n_errors = 0;
    typedef struct {logic [31:0] val; logic chg;} exp_t;
    typedef struct {logic [31:0] val; int hold; bit frame;} vec_t;
    exp_t q[$];
    exp_t e;
    vec_t vecs[6];
    logic [31:0] last_val = 32'hFFFF_FFFF;
    bit first = 1'b1;
    int lat;

    seven_sd_capture dut (
        .clk(clk), .rst(rst), .segIn(segIn), .anodeIn(anodeIn), .value(value),
        .frameValid(frameValid), .valueChanged(valueChanged), .digitSeen(digitSeen),
        .anodeError(anodeError)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic [7:0] s, input int n);
        anodeIn = ~(4'b1 << d);
        segIn = s;
        step(n);
    endtask

    task automatic blank(input int n);
        anodeIn = 4'hF;
        segIn = 8'hFF;
        step(n);
    endtask

    task automatic push_exp(input logic [31:0] v);
        q.push_back('{val: v, chg: first || v != last_val});
        last_val = v;
        first = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] v, input int hold, input bit exp_frame);
        if (exp_frame) push_exp(v);
        for (int d = 0; d < 4; d++) drive(d, v[8*d +: 8], hold);
        blank(8);
        check("seen_after_frame", {28'd0, digitSeen}, 32'd0);
    endtask

    // Scoreboard: every published frame must match the oldest pending expectation
    always @(negedge clk) begin
        if (frameValid) begin
            if (q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_frame: got value %h, expected no frame", value);
            end else begin
                e = q.pop_front();
                check("frame_value", value, e.val);
                check("frame_changed", {31'd0, valueChanged}, {31'd0, e.chg});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h7FE7935C, 16, 1'b1};
        vecs[1] = '{32'h7FE7935C, 20, 1'b1};
        vecs[2] = '{32'h7FE7935C, 15, 1'b0};
        vecs[3] = '{32'h00FF00FF, 16, 1'b1};
        vecs[4] = '{32'h00FF00FF, 17, 1'b1};
        vecs[5] = '{32'h12345678, 16, 1'b1};
        step(3);
        rst = 1'b0;
        step(1);
        check("rst_value", value, 32'hFFFF_FFFF);
        check("rst_frame_valid", {31'd0, frameValid}, 32'd0);
        check("rst_value_changed", {31'd0, valueChanged}, 32'd0);
        check("rst_digit_seen", {28'd0, digitSeen}, 32'd0);
        check("rst_anode_error", {31'd0, anodeError}, 32'd0);
        blank(4);
        for (int i = 0; i < 6; i++) send_frame(vecs[i].val, vecs[i].hold, vecs[i].frame);
        check("no_error_yet", {31'd0, anodeError}, 32'd0);

        // Pin-to-frameValid latency for the last digit
        push_exp(32'hA1B2C3D4);
        drive(0, 8'hD4, 16);
        drive(1, 8'hC3, 16);
        drive(2, 8'hB2, 16);
        anodeIn = 4'b0111;
        segIn = 8'hA1;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (frameValid) begin
                lat = k;
                break;
            end
        end
        check("latency", lat, 32'd19);
        @(posedge clk);
        #1;
        blank(8);

        // Segment glitch on digit 2 must re-settle and keep A4
        push_exp(32'hC0A4F9B0);
        drive(0, 8'hB0, 16);
        drive(1, 8'hF9, 16);
        drive(2, 8'hA4, 16);
        drive(2, 8'h00, 3);
        check("glitch_seen", {28'd0, digitSeen}, 32'h7);
        drive(2, 8'hA4, 16);
        drive(3, 8'hC0, 16);
        blank(8);

        // Two anodes low for one cycle sets the sticky error
        anodeIn = 4'b0011;
        step(1);
        blank(4);
        check("anode_error_set", {31'd0, anodeError}, 32'd1);
        send_frame(32'h5A5A1234, 16, 1'b1);
        check("anode_error_sticky", {31'd0, anodeError}, 32'd1);

        // Reset mid-frame discards the partial frame
        drive(0, 8'h11, 16);
        drive(1, 8'h22, 16);
        drive(2, 8'h33, 16);
        blank(4);
        check("partial_seen", {28'd0, digitSeen}, 32'h7);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mid_rst_value", value, 32'hFFFF_FFFF);
        check("mid_rst_seen", {28'd0, digitSeen}, 32'd0);
        check("mid_rst_error", {31'd0, anodeError}, 32'd0);
        first = 1'b1;
        send_frame(32'h5A5A1234, 16, 1'b1);
        send_frame(32'h5A5A1234, 16, 1'b1);
        blank(10);
        check("scoreboard_empty", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
